cbadc_ctrl_tx: RTL and testbench

Control-bit stream transmitter for the control-bounded ADC decimation chain. It buffers N-bit control vectors arriving on a valid/ready write port and replays them, one per `clk`, onto the decimation filter's `in` bus. Alongside each vector it emits the OSR frame phase and a frame-start strobe, and it detects underrun. It sits directly upstream of the FIR decimator, in both test benches and FPGA playback builds.

---
 rtl/cbadc_tx_pkg.sv | 14 +
 rtl/ctrl_fifo.sv | 54 +++++
 rtl/cbadc_ctrl_tx.sv | 158 +++++++++++++++
 tb/tb_cbadc_ctrl_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cbadc_tx_pkg.sv
// Shared types for the control-bit stream transmitter.
package cbadc_tx_pkg;

  // Control-vector width; tracks the FIR decimator's input width (Coefficients_FIR1::N).
  localparam int unsigned CtrlWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StFault
  } tx_state_e;

endpackage

// File: rtl/ctrl_fifo.sv
// Synchronous FIFO with occupancy count, flush, and async active-low reset.
module ctrl_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 32,
  localparam int unsigned LvlW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic [LvlW-1:0]  level,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(Depth));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + LvlW'(do_push) - LvlW'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cbadc_ctrl_tx.sv
// Replays buffered control vectors one per clock onto the decimator input,
// with OSR frame phase, frame-start strobe and sticky underrun detection.
module cbadc_ctrl_tx
  import cbadc_tx_pkg::*;
#(
  parameter int unsigned N           = CtrlWidth,
  parameter int unsigned OSR         = 12,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned PRIME_LEVEL = OSR,
  localparam int unsigned PhW        = $clog2(OSR),
  localparam int unsigned LvlW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            start,
  input  logic            stop,
  output logic [N-1:0]    ctrl_out,
  output logic            ctrl_valid,
  output logic [PhW-1:0]  phase,
  output logic            frame_start,
  output logic            underrun,
  output logic [LvlW-1:0] level
);

  tx_state_e      state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic [PhW-1:0] ph_q, ph_d, emit_ph;
  logic           und_q, und_d;
  logic           pend_q, pend_d;
  logic           last_q, last_d;

  logic           fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [N-1:0]   fifo_rdata;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;

  ctrl_fifo #(
    .Width (N),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .level (level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      valid_q <= 1'b0;
      ph_q    <= '0;
      und_q   <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ph_q    <= ph_d;
      und_q   <= und_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && !stop) state_d = StPrime;
      StPrime: begin
        if (stop)                            state_d = StIdle;
        else if (32'(level) >= PRIME_LEVEL)  state_d = StRun;
      end
      StRun: begin
        if (last_q)          state_d = StIdle;
        else if (fifo_empty) state_d = StFault;
      end
      StFault: begin
        if (stop)       state_d = StIdle;
        else if (start) state_d = StPrime;
      end
      default: state_d = StIdle;
    endcase
  end

  // Phase of the vector the next pop presents; a fresh run always begins at 0.
  assign emit_ph = !valid_q ? '0 : (ph_q == PhW'(OSR - 1)) ? '0 : ph_q + 1'b1;

  always_comb begin
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q;
    ph_d       = ph_q;
    und_d      = und_q;
    pend_d     = pend_q;
    last_d     = last_q;
    unique case (state_q)
      StRun: begin
        if (last_q || fifo_empty) begin
          data_d     = '0;
          valid_d    = 1'b0;
          ph_d       = '0;
          pend_d     = 1'b0;
          last_d     = 1'b0;
          und_d      = und_q || !last_q;
          fifo_flush = !last_q;
        end else begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          valid_d  = 1'b1;
          ph_d     = emit_ph;
          // A stop seen only at the edge emitting OSR-1 is deferred a full frame.
          if (pend_q && emit_ph == PhW'(OSR - 1)) begin
            last_d = 1'b1;
            pend_d = 1'b0;
          end else if (stop) begin
            pend_d = 1'b1;
          end
        end
      end
      StFault: begin
        data_d  = '0;
        valid_d = 1'b0;
        ph_d    = '0;
        pend_d  = 1'b0;
        last_d  = 1'b0;
        if (start && !stop) und_d = 1'b0;
      end
      default: begin
        data_d  = '0;
        valid_d = 1'b0;
        ph_d    = '0;
        pend_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  assign ctrl_out    = data_q;
  assign ctrl_valid  = valid_q;
  assign phase       = ph_q;
  assign frame_start = valid_q && (ph_q == '0);
  assign underrun    = und_q;

endmodule

// File: tb/tb_cbadc_ctrl_tx.sv
// Scoreboard bench for cbadc_ctrl_tx: accepted writes are queued and compared
// against every replayed vector; phase and strobe are tracked independently.
module tb_cbadc_ctrl_tx;
  import cbadc_tx_pkg::*;

  localparam int N     = 4;
  localparam int OSR   = 12;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         start;
  logic         stop;
  logic [N-1:0] ctrl_out;
  logic         ctrl_valid;
  logic [3:0]   phase;
  logic         frame_start;
  logic         underrun;
  logic [5:0]   level;

  int total = 0;
  int bad   = 0;
  int exp_ph = 0;
  int n_seen = 0;
  int seen0;
  logic [N-1:0] sb_q[$];

  cbadc_ctrl_tx #(
    .N           (N),
    .OSR         (OSR),
    .DEPTH       (DEPTH),
    .PRIME_LEVEL (OSR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .start       (start),
    .stop        (stop),
    .ctrl_out    (ctrl_out),
    .ctrl_valid  (ctrl_valid),
    .phase       (phase),
    .frame_start (frame_start),
    .underrun    (underrun),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (ctrl_valid) begin
      n_seen++;
      if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 1);
      else                  check("data", ctrl_out, sb_q.pop_front());
      check("phase", phase, exp_ph);
      check("frame_start", frame_start, exp_ph == 0);
      exp_ph = (exp_ph == OSR - 1) ? 0 : exp_ph + 1;
    end else begin
      exp_ph = 0;
      check("idle_data", ctrl_out, 0);
      check("idle_phase", phase, 0);
      check("idle_fs", frame_start, 0);
    end
  end

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = N'(base + i);
      if (s_ready) sb_q.push_back(N'(base + i));
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  // Asserts reset between edges and checks outputs clear without a clock.
  task automatic reset_mid();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_valid", ctrl_valid, 0);
    check("rst_data", ctrl_out, 0);
    check("rst_phase", phase, 0);
    check("rst_fs", frame_start, 0);
    check("rst_und", underrun, 0);
    check("rst_level", level, 0);
    check("rst_ready", s_ready, 1);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    s_valid = 1'b0;
    s_data  = '0;
    start   = 1'b0;
    stop    = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("por_valid", ctrl_valid, 0);
    check("por_ready", s_ready, 1);
    check("por_level", level, 0);
    check("por_und", underrun, 0);
    @(negedge clk); rst = 1'b1;

    // Playback of one frame, then underrun on the 13th pop.
    push_n(12, 1);
    check("pb_level", level, 12);
    pulse_start();
    check("pb_lat0", ctrl_valid, 0);
    @(negedge clk); check("pb_lat1", ctrl_valid, 0);
    @(negedge clk);
    check("pb_first_v", ctrl_valid, 1);
    check("pb_first_fs", frame_start, 1);
    check("pb_first_d", ctrl_out, 1);
    repeat (11) @(negedge clk);
    check("pb_last_v", ctrl_valid, 1);
    check("pb_last_ph", phase, 11);
    check("pb_last_d", ctrl_out, 12);
    @(negedge clk);
    check("ur_valid", ctrl_valid, 0);
    check("ur_flag", underrun, 1);
    check("ur_level", level, 0);
    check("pb_seen", n_seen, 12);

    // Recovery from FAULT.
    push_n(12, 13);
    pulse_start();
    check("ur_cleared", underrun, 0);
    @(negedge clk); @(negedge clk);
    check("res_valid", ctrl_valid, 1);
    check("res_phase", phase, 0);
    check("res_data", ctrl_out, 13);
    repeat (3) @(negedge clk);
    reset_mid();

    // Full FIFO: 33rd write refused, first 32 replay in order.
    push_n(33, 0);
    check("full_level", level, 32);
    check("full_ready", s_ready, 0);
    check("full_accepted", 32'(sb_q.size()), 32);
    seen0 = n_seen;
    pulse_start();
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (underrun) found = 1;
    end
    check("full_ur", underrun, 1);
    check("full_seen", n_seen - seen0, 32);
    pulse_stop();
    repeat (2) @(negedge clk);
    check("fault_stop_ur", underrun, 1);
    check("fault_stop_v", ctrl_valid, 0);
    reset_mid();

    // Simultaneous start+stop in IDLE: stop wins.
    push_n(24, 1);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    check("ss_valid", ctrl_valid, 0);
    check("ss_level", level, 24);

    // Stop mid-frame at phase 5: rest of frame still plays.
    seen0 = n_seen;
    pulse_start();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ctrl_valid && phase == 5) found = 1;
    end
    check("stop_found_ph5", phase, 5);
    stop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stop = 1'b0;
      check("stop_valid", ctrl_valid, 1);
      check("stop_phase", phase, 6 + i);
    end
    @(negedge clk);
    check("stop_fall", ctrl_valid, 0);
    check("stop_level", level, 12);
    check("stop_seen", n_seen - seen0, 12);
    repeat (3) @(negedge clk);
    check("stop_idle_v", ctrl_valid, 0);
    check("stop_idle_lvl", level, 12);

    // Steady RUN with one push per pop: level holds at 12.
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("pp_level", level, 12);
      check("pp_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data  = N'(i + 3);
      sb_q.push_back(N'(i + 3));
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("pp_level_end", level, 12);
    check("pp_und", underrun, 0);
    check("pp_valid", ctrl_valid, 1);
    pulse_stop();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (!ctrl_valid) found = 1;
    end
    check("pp_stopped", ctrl_valid, 0);
    check("pp_und_end", underrun, 0);
    check("pp_sb_level", level, 32'(sb_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
